// File: rtl/constants.sv
// Shared widths, state/ID encodings and defaults for the data-memory arbiter.
package constants;
  localparam int WORD_SIZE         = 19;
  localparam int DMEM_ADDR_W       = 10;
  localparam int DMEM_STARVE_LIMIT = 4;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_RESP} dmem_arb_state_t;
  typedef enum logic {REQ_CPU, REQ_DMA} dmem_req_id_t;
endpackage

// File: rtl/dmem_starve_counter.sv
// Saturating count of CPU wins taken while DMA was waiting; flags when DMA is owed the next slot.
module dmem_starve_counter
  import constants::*;
#(
  parameter int LIMIT = DMEM_STARVE_LIMIT
) (
  input  logic clk,
  input  logic RESET,
  input  logic inc,
  input  logic clr,
  output logic limit_hit
);
  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(LIMIT);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (RESET)                    r_cnt <= '0;
    else if (clr)                 r_cnt <= '0;
    else if (inc && r_cnt != LIM) r_cnt <= r_cnt + 1'b1;
  end

  assign limit_hit = (r_cnt == LIM);
endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (CPU/DMA) serializing arbiter for the 1024x19 data memory; all outputs registered.
// Define DMEM_ARB_STARVE_EN to bound how long a waiting DMA request can lose to the CPU.
module dmem_arbiter
  import constants::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W
`ifdef DMEM_ARB_STARVE_EN
  , parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
`endif
) (
  input  logic                 clk,
  input  logic                 RESET,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [WORD_SIZE-1:0] cpu_wdata,
  output logic                 cpu_gnt,
  output logic                 cpu_rvalid,
  output logic [WORD_SIZE-1:0] cpu_rdata,
  input  logic                 dma_req,
  input  logic                 dma_we,
  input  logic [ADDR_W-1:0]    dma_addr,
  input  logic [WORD_SIZE-1:0] dma_wdata,
  output logic                 dma_gnt,
  output logic                 dma_rvalid,
  output logic [WORD_SIZE-1:0] dma_rdata,
  output logic                 mem_wr_en,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic                 busy
);
  dmem_arb_state_t r_state;
  dmem_req_id_t    r_id;
  logic            r_we;

  logic                 w_limit_hit, w_pick_dma, w_any_req, w_sel_we;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [WORD_SIZE-1:0] w_sel_wdata;

  assign w_any_req   = cpu_req | dma_req;
  assign w_pick_dma  = dma_req & (~cpu_req | w_limit_hit);
  assign w_sel_we    = w_pick_dma ? dma_we    : cpu_we;
  assign w_sel_addr  = w_pick_dma ? dma_addr  : cpu_addr;
  assign w_sel_wdata = w_pick_dma ? dma_wdata : cpu_wdata;

`ifdef DMEM_ARB_STARVE_EN
  logic w_inc, w_clr;

  // Count only decisions made in IDLE; any IDLE cycle without a DMA request forgives the debt.
  assign w_inc = (r_state == ARB_IDLE) & cpu_req & dma_req & ~w_pick_dma;
  assign w_clr = (r_state == ARB_IDLE) & (~dma_req | w_pick_dma);

  dmem_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk       (clk),
    .RESET     (RESET),
    .inc       (w_inc),
    .clr       (w_clr),
    .limit_hit (w_limit_hit)
  );
`else
  assign w_limit_hit = 1'b0;
`endif

  // mem_addr/mem_wdata double as the latched command; they hold after the access.
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state    <= ARB_IDLE;
      r_id       <= REQ_CPU;
      r_we       <= 1'b0;
      cpu_gnt    <= 1'b0;
      dma_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
      mem_wr_en  <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      cpu_gnt    <= 1'b0;
      dma_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_rd_en  <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_any_req) begin
            r_id      <= w_pick_dma ? REQ_DMA : REQ_CPU;
            r_we      <= w_sel_we;
            mem_wr_en <= w_sel_we;
            mem_rd_en <= ~w_sel_we;
            mem_addr  <= w_sel_addr;
            mem_wdata <= w_sel_wdata;
            cpu_gnt   <= ~w_pick_dma;
            dma_gnt   <= w_pick_dma;
            busy      <= 1'b1;
            r_state   <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (r_we) begin
            busy    <= 1'b0;
            r_state <= ARB_IDLE;
          end else begin
            r_state <= ARB_RESP;
          end
        end
        ARB_RESP: begin
          if (r_id == REQ_DMA) begin
            dma_rdata  <= mem_rdata;
            dma_rvalid <= 1'b1;
          end else begin
            cpu_rdata  <= mem_rdata;
            cpu_rvalid <= 1'b1;
          end
          busy    <= 1'b0;
          r_state <= ARB_IDLE;
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-timeline model compared every cycle, plus directed literal checks.
module tb_dmem_arbiter;
  localparam int D     = 1024;
  localparam int LIMIT = 4;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
  logic [9:0]  cpu_addr = '0, dma_addr = '0;
  logic [18:0] cpu_wdata = '0, dma_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, dma_gnt, dma_rvalid;
  logic [18:0] cpu_rdata, dma_rdata;
  logic        mem_wr_en, mem_rd_en, busy;
  logic [9:0]  mem_addr;
  logic [18:0] mem_wdata;
  logic [18:0] mem_rdata = '0;

  dmem_arbiter dut (
    .clk(clk), .RESET(RESET),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // Data memory device: write at clock edge, registered read data.
  bit [18:0] dev_mem [1024];
  always @(posedge clk) begin
    if (mem_wr_en === 1'b1) dev_mem[mem_addr] <= mem_wdata;
    if (mem_rd_en === 1'b1) mem_rdata <= dev_mem[mem_addr];
  end

  int n_pass = 0, n_total = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Model: per-cycle expected outputs, scheduled from the request/response timeline.
  bit        e_cg[D], e_dg[D], e_wr[D], e_rd[D], e_busy[D], e_cv[D], e_dv[D], e_rst[D];
  bit [9:0]  e_addr[D];
  bit [18:0] e_wd[D], e_rval[D], e_cr[D], e_dr[D];
  bit [18:0] ref_mem[1024];
  int        free_at = 0, scnt = 0, m_k;
  bit        armed = 1'b0, m_dma, m_we;
  bit [9:0]  m_a;
  bit [18:0] m_d;

  always @(posedge clk) begin
    cyc++;
    m_k = cyc;
    if (m_k < D - 4) begin
      if (RESET) begin
        armed = 1'b1; free_at = m_k; scnt = 0;
        for (int j = 0; j < 4; j++) begin
          e_cg[m_k+j] = 0; e_dg[m_k+j] = 0; e_wr[m_k+j] = 0; e_rd[m_k+j] = 0;
          e_busy[m_k+j] = 0; e_cv[m_k+j] = 0; e_dv[m_k+j] = 0;
          e_addr[m_k+j] = '0; e_wd[m_k+j] = '0;
        end
        e_rst[m_k] = 1'b1; e_cr[m_k] = '0; e_dr[m_k] = '0;
      end else if (armed) begin
        // Inputs seen here belong to cycle m_k-1; arbitrate if that cycle was idle.
        if (m_k - 1 >= free_at) begin
          m_dma = dma_req && (!cpu_req || (STARVE_ON && scnt == LIMIT));
          if (!dma_req || m_dma) scnt = 0;
          else if (cpu_req && scnt < LIMIT) scnt++;
          if (cpu_req || dma_req) begin
            m_we = m_dma ? dma_we : cpu_we;
            m_a  = m_dma ? dma_addr : cpu_addr;
            m_d  = m_dma ? dma_wdata : cpu_wdata;
            e_cg[m_k] = !m_dma; e_dg[m_k] = m_dma;
            e_wr[m_k] = m_we;   e_rd[m_k] = !m_we;
            e_addr[m_k] = m_a;  e_wd[m_k] = m_d;  e_busy[m_k] = 1'b1;
            if (m_we) begin
              ref_mem[m_a] = m_d;
              free_at = m_k + 1;
            end else begin
              e_busy[m_k+1] = 1'b1;
              if (m_dma) e_dv[m_k+2] = 1'b1; else e_cv[m_k+2] = 1'b1;
              e_rval[m_k+2] = ref_mem[m_a];
              free_at = m_k + 2;
            end
          end
        end
        e_cr[m_k] = e_cv[m_k] ? e_rval[m_k] : e_cr[m_k-1];
        e_dr[m_k] = e_dv[m_k] ? e_rval[m_k] : e_dr[m_k-1];
      end
    end
  end

  always @(negedge clk) begin
    if (armed && cyc < D - 4) begin
      chk("cpu_gnt",    32'(cpu_gnt),    32'(e_cg[cyc]));
      chk("dma_gnt",    32'(dma_gnt),    32'(e_dg[cyc]));
      chk("mem_wr_en",  32'(mem_wr_en),  32'(e_wr[cyc]));
      chk("mem_rd_en",  32'(mem_rd_en),  32'(e_rd[cyc]));
      chk("busy",       32'(busy),       32'(e_busy[cyc]));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_cv[cyc]));
      chk("dma_rvalid", 32'(dma_rvalid), 32'(e_dv[cyc]));
      chk("cpu_rdata",  32'(cpu_rdata),  32'(e_cr[cyc]));
      chk("dma_rdata",  32'(dma_rdata),  32'(e_dr[cyc]));
      if (e_wr[cyc] || e_rd[cyc] || e_rst[cyc]) begin
        chk("mem_addr",  32'(mem_addr),  32'(e_addr[cyc]));
        chk("mem_wdata", 32'(mem_wdata), 32'(e_wd[cyc]));
      end
    end
  end

  // Directed stimulus: poll records first-event cycles and reacts to grants like a requester.
  int        t0, t_cg, t_dg, t_cv, t_dv, n_cg, n_dg, n_act, cg_before_dg;
  logic [18:0] cv_data, dv_data;
  bit        cpu_hold = 1'b0;

  task automatic poll(input int n);
    t_cg = -1; t_dg = -1; t_cv = -1; t_dv = -1;
    n_cg = 0; n_dg = 0; n_act = 0; cg_before_dg = -1;
    repeat (n) begin
      @(negedge clk);
      if ((busy | mem_wr_en | mem_rd_en | cpu_gnt | dma_gnt | cpu_rvalid | dma_rvalid) !== 1'b0)
        n_act++;
      if (dma_gnt === 1'b1) begin
        n_dg++;
        if (t_dg < 0) begin t_dg = cyc; cg_before_dg = n_cg; end
        dma_req = 1'b0;
      end
      if (cpu_gnt === 1'b1) begin
        n_cg++;
        if (t_cg < 0) t_cg = cyc;
        if (cpu_hold) begin
          cpu_addr  = cpu_addr + 10'd1;
          cpu_wdata = cpu_wdata + 19'd1;
        end else cpu_req = 1'b0;
      end
      if (cpu_rvalid === 1'b1 && t_cv < 0) begin t_cv = cyc; cv_data = cpu_rdata; end
      if (dma_rvalid === 1'b1 && t_dv < 0) begin t_dv = cyc; dv_data = dma_rdata; end
    end
  endtask

  task automatic cpu_cmd(input logic we, input logic [9:0] a, input logic [18:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dma_cmd(input logic we, input logic [9:0] a, input logic [18:0] d);
    dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    dev_mem[16] = 19'h00007;
    ref_mem[16] = 19'h00007;
    repeat (3) @(negedge clk);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    RESET = 1'b0;
    poll(2);

    // CPU write then read-back
    cpu_cmd(1'b1, 10'h005, 19'h1ABCD); t0 = cyc; poll(3);
    chk("wr_gnt_lat", 32'(t_cg - t0), 32'd1);
    cpu_cmd(1'b0, 10'h005, 19'h0); t0 = cyc; poll(5);
    chk("rd_gnt_lat",    32'(t_cg - t0), 32'd1);
    chk("rd_rvalid_lat", 32'(t_cv - t0), 32'd3);
    chk("rd_data",       32'(cv_data),   32'h1ABCD);

    // Simultaneous: CPU read wins, DMA write follows at the next arbitration
    cpu_cmd(1'b0, 10'h010, 19'h0); dma_cmd(1'b1, 10'h010, 19'h00042); t0 = cyc; poll(8);
    chk("sim_cpu_gnt_lat", 32'(t_cg - t0), 32'd1);
    chk("sim_cpu_rv_lat",  32'(t_cv - t0), 32'd3);
    chk("sim_cpu_data",    32'(cv_data),   32'h00007);
    chk("sim_dma_gnt_lat", 32'(t_dg - t0), 32'd4);
    cpu_cmd(1'b0, 10'h010, 19'h0); t0 = cyc; poll(5);
    chk("sim_readback", 32'(cv_data), 32'h00042);

    // Cross-port ordering at the top address
    dma_cmd(1'b1, 10'h3FF, 19'h7FFFF); t0 = cyc; poll(3);
    chk("xp_dma_gnt_lat", 32'(t_dg - t0), 32'd1);
    cpu_cmd(1'b0, 10'h3FF, 19'h0); t0 = cyc; poll(5);
    chk("xp_data", 32'(cv_data), 32'h7FFFF);

    // Starvation: CPU streams writes while DMA waits
    cpu_hold = 1'b1;
    cpu_cmd(1'b1, 10'h100, 19'h00011); dma_cmd(1'b1, 10'h200, 19'h00022); t0 = cyc; poll(24);
    if (STARVE_ON) begin
      chk("stv_dma_gnts",    32'(n_dg),         32'd1);
      chk("stv_cpu_before",  32'(cg_before_dg), 32'd4);
      chk("stv_dma_gnt_lat", 32'(t_dg - t0),    32'd9);
    end else begin
      chk("stv_dma_gnts", 32'(n_dg), 32'd0);
      chk("stv_cpu_gnts", 32'(n_cg), 32'd12);
    end
    cpu_hold = 1'b0; cpu_req = 1'b0; poll(4);

    // Reset during RESP aborts the read
    cpu_cmd(1'b0, 10'h005, 19'h0); poll(2);
    RESET = 1'b1; poll(1);
    chk("rr_rvalid", 32'(cpu_rvalid), 32'd0);
    chk("rr_busy",   32'(busy),       32'd0);
    chk("rr_rdata",  32'(cpu_rdata),  32'd0);
    RESET = 1'b0; poll(6);
    chk("rr_no_rvalid", 32'(t_cv), 32'hFFFF_FFFF);

    // Idle
    poll(20);
    chk("idle_activity", 32'(n_act), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
